// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port data RAM arbiter.
package ram_arb_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_t;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 16;

  // The port that is not p; used to hand priority to the loser.
  function automatic port_sel_t other_port(input port_sel_t p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant picker: a lone request wins outright, a contested
// cycle is settled by prio. With no request, sel rests on PORT_A so the
// RAM mux shows port A values.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic      req_a,
  input  logic      req_b,
  input  port_sel_t prio,
  output logic      gnt_a,
  output logic      gnt_b,
  output port_sel_t sel
);

  // Choose the winning port and derive the one-hot grants from it.
  always_comb begin
    sel = PORT_A;
    if (req_a && req_b) begin
      sel = prio;
    end else if (req_b) begin
      sel = PORT_B;
    end
    gnt_a = req_a && (sel == PORT_A);
    gnt_b = req_b && (sel == PORT_B);
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter sharing the single-port data RAM between the CPU core (port A)
// and the loader/debug requester (port B). One word per cycle, grant in
// the same cycle as the request, read data returned one cycle later.
// Optional build macro: RAM_ARB_ROUND_ROBIN_EN (alternating priority);
// without it port A always wins a contested cycle.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_a_req,
  input  logic                  i_a_we,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [DATA_WIDTH-1:0] i_a_wdata,
  input  logic                  i_b_req,
  input  logic                  i_b_we,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [DATA_WIDTH-1:0] i_b_wdata,
  output logic                  o_a_gnt,
  output logic                  o_b_gnt,
  output logic                  o_a_rvalid,
  output logic                  o_b_rvalid,
  output logic [DATA_WIDTH-1:0] o_a_rdata,
  output logic [DATA_WIDTH-1:0] o_b_rdata,
  output logic                  o_ram_load,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  input  logic [DATA_WIDTH-1:0] i_ram_data
);

  port_sel_t prio;
  port_sel_t sel;
  port_sel_t rd_port;
  logic      rd_pend;
  logic      req_a;
  logic      req_b;
  logic      gnt_a;
  logic      gnt_b;
  logic      gnt_any;
  logic      sel_we;
  logic      rd_grant;

  // Requests are ignored while reset is held, which also forces load low.
  assign req_a = i_a_req && !i_reset;
  assign req_b = i_b_req && !i_reset;

  ram_arb_pick u_pick (
    .req_a (req_a),
    .req_b (req_b),
    .prio  (prio),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b),
    .sel   (sel)
  );

  assign gnt_any  = gnt_a || gnt_b;
  assign sel_we   = (sel == PORT_B) ? i_b_we : i_a_we;
  assign rd_grant = gnt_any && !sel_we;

  assign o_a_gnt    = gnt_a;
  assign o_b_gnt    = gnt_b;
  assign o_ram_load = gnt_any && sel_we;
  assign o_ram_addr = (sel == PORT_B) ? i_b_addr  : i_a_addr;
  assign o_ram_data = (sel == PORT_B) ? i_b_wdata : i_a_wdata;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Priority moves to the port that did not get the last grant, so a
  // waiting port is served within one cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      prio <= PORT_A;
    end else if (gnt_any) begin
      prio <= other_port(sel);
    end
  end
`else
  assign prio = PORT_A;
`endif

  // Remember which port owns the read whose data arrives next cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_pend <= 1'b0;
      rd_port <= PORT_A;
    end else begin
      rd_pend <= rd_grant;
      if (rd_grant) begin
        rd_port <= sel;
      end
    end
  end

  // The RAM output is already registered; only the valid strobe is steered.
  assign o_a_rvalid = rd_pend && (rd_port == PORT_A);
  assign o_b_rvalid = rd_pend && (rd_port == PORT_B);
  assign o_a_rdata  = i_ram_data;
  assign o_b_rdata  = i_ram_data;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter sharing the single-port data RAM between the CPU core (port A) and a secondary requester (port B: program loader / debug UART). Each cycle it grants at most one single-word read or write, drives the RAM's `i_load`/`i_addr`/`i_data` inputs, and routes the RAM's registered read data back to the requester that issued the read. It sits between the core's data-access logic and the `ram` instance.

## Interface
- `ADDR_WIDTH`, 8, RAM address width; matches the data RAM.
- `DATA_WIDTH`, 16, RAM word width.
- `i_clk`  in  1  system clock; all state on rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_a_req` / `i_b_req`  in  1  request valid; held with its qualifiers until granted.
- `i_a_we` / `i_b_we`  in  1  1 = write, 0 = read.
- `i_a_addr` / `i_b_addr`  in  ADDR_WIDTH  word address.
- `i_a_wdata` / `i_b_wdata`  in  DATA_WIDTH  write data.
- `o_a_gnt` / `o_b_gnt`  out  1  combinational grant; transfer occurs on the edge where req & gnt.
- `o_a_rvalid` / `o_b_rvalid`  out  1  read data valid, one cycle after a granted read.
- `o_a_rdata` / `o_b_rdata`  out  DATA_WIDTH  read data; meaningful only while the matching rvalid is high.
- `o_ram_load`  out  1  to RAM `i_load`.
- `o_ram_addr`  out  ADDR_WIDTH  to RAM `i_addr`.
- `o_ram_data`  out  DATA_WIDTH  to RAM `i_data`.
- `i_ram_data`  in  DATA_WIDTH  from RAM `o_data`; registered, valid the cycle after the address is presented.

## Operation
- Grant: if exactly one req is high, that port is granted. If both are high, the winner comes from the priority state `prio` (reg, PORT_A or PORT_B). With no req, no grant.
- RAM drive from the selected port: `o_ram_addr` = sel addr, `o_ram_data` = sel wdata, `o_ram_load` = gnt & sel we. With no grant: load = 0, addr/data hold port A values (don't-care).
- Read return: `rd_pend` (1 bit) and `rd_port` (1 bit) are registered on every granted read. The next cycle asserts the matching rvalid for exactly one cycle. Both rdata outputs are `i_ram_data` passed straight through.
- Writes produce no rvalid. The grant is the write acknowledge.
- Requester rule: req, we, addr and wdata stay stable from assertion until the cycle gnt is seen. A req may be held high on consecutive cycles for back-to-back transfers.
- Boundaries:
  - Read and write to the same address in consecutive cycles follow RAM semantics. A read granted the cycle after a write returns the new data.
  - Address wrap is the RAM's own.
  - A req dropped before grant is legal and is discarded.

## Timing
- Reset values: `prio` = PORT_A, `rd_pend` = 0, `rd_port` = PORT_A, both rvalid = 0.
- While `i_reset` is high, both gnt and `o_ram_load` are forced 0.
- Reset asserted in the cycle after a granted read suppresses that read's rvalid.
- Grant latency is 0 cycles (same cycle as req). Read latency is 1 cycle from the grant edge to rvalid.
- Throughput is one transfer per cycle. Reads from alternating ports pipeline, so rvalid A and rvalid B never assert in the same cycle.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN` defined: after every contested grant, `prio` flips to the loser. An uncontested grant sets `prio` to the other port. No port waits more than 1 cycle while the other holds req.
- Not defined: fixed priority. Port A always wins, `prio` is constant PORT_A, and port B can starve.

## Structure
- Package `ram_arb_pkg`:
  - `port_sel_t` enum, PORT_A = 0, PORT_B = 1.
  - Default width constants.
- Sub-module `ram_arb_pick`: purely combinational. Takes (req_a, req_b, prio) and returns (gnt_a, gnt_b, sel). The top-level block holds `prio`, the read-return registers and the RAM muxing.

## Test plan
- Reset, then A reads addr 0x10 (RAM preloaded 0x1234) → `o_a_gnt` = 1 in cycle 0; `o_a_rvalid` = 1 with `o_a_rdata` = 0x1234 in cycle 1; `o_b_rvalid` stays 0.
- B writes 0xBEEF to 0x20, then B reads 0x20 the next cycle → `o_ram_load` is high for one cycle; the read returns 0xBEEF.
- A and B both hold read reqs for 4 cycles:
  - With RR: grants A, B, A, B; rvalids alternate A, B, A, B.
  - Without RR: A is granted all 4 cycles; B gets no grant.
- Simultaneous write from A (0x05 ← 0x1111) and read from B (0x05) with RR at reset → A is granted first, B second; B reads 0x1111.
- A read is granted, then `i_reset` pulses in the next cycle → no rvalid; all outputs are at reset values; the first request after reset is granted normally.
- B asserts req then drops it before grant while A is busy → no B transfer; `o_ram_load` never reflects B's we.
